game_state_ctrl: RTL and testbench

- Produces the 4-bit game state code that drives the 7-segment display (IDLE / HOLA / play levels / OVER).
- Takes the three raw board push-buttons, synchronises and debounces them, and turns each clean press into a one-cycle event.
- Runs the game state machine and its timers, all in the 1 kHz domain.

---
 rtl/game_state_ctrl_if.sv | 29 ++
 rtl/game_state_ctrl.sv | 163 ++++++++++++++++
 tb/tb_game_state_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/game_state_ctrl_if.sv
// Button/display bundle between the board and the game state controller.
// Latency: none, wires only.
// Backpressure: none; buttons are free-running levels, outputs are registered levels/pulses.
//
// Signals:
//   btn_start, btn_step, btn_quit : raw asynchronous push-buttons, active-high
//   state                         : 4-bit game state code for the 7-segment display
//   over_cause                    : why the game ended, nonzero only while in OVER
//   state_chg                     : one-cycle pulse the cycle after state changes
interface game_state_ctrl_if;
    logic       btn_start;
    logic       btn_step;
    logic       btn_quit;
    logic [3:0] state;
    logic [1:0] over_cause;
    logic       state_chg;

    // master drives the buttons and observes the display outputs
    modport master (
        output btn_start, btn_step, btn_quit,
        input  state, over_cause, state_chg
    );

    // slave is the controller itself
    modport slave (
        input  btn_start, btn_step, btn_quit,
        output state, over_cause, state_chg
    );
endinterface

// File: rtl/game_state_ctrl.sv
// Game state controller: sync + debounce three buttons, run IDLE/HOLA/PLAY1..4/OVER FSM with timers.
// Latency: raw press held from edge 1 changes state at edge DEBOUNCE_MS+3; state_chg one edge later.
// Backpressure: none; presses arriving while an event is ignored or outranked are dropped.
//
// Ports:
//   clk_1KHz : 1 kHz system clock
//   rst_n    : asynchronous active-low reset
//   bus      : slave side of game_state_ctrl_if (buttons in, state/over_cause/state_chg out)
module game_state_ctrl #(
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned GREET_MS    = 2000,
    parameter int unsigned OVER_MS     = 3000,
    parameter int unsigned INACT_MS    = 10000
) (
    input  logic              clk_1KHz,
    input  logic              rst_n,
    game_state_ctrl_if.slave  bus
);

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_HOLA  = 4'd1,
        ST_PLAY1 = 4'd2,
        ST_PLAY2 = 4'd3,
        ST_PLAY3 = 4'd4,
        ST_PLAY4 = 4'd5,
        ST_OVER  = 4'd6
    } state_t;

    localparam logic [1:0] CAUSE_NONE = 2'd0;
    localparam logic [1:0] CAUSE_DONE = 2'd1;
    localparam logic [1:0] CAUSE_QUIT = 2'd2;
    localparam logic [1:0] CAUSE_TMO  = 2'd3;

    localparam logic [7:0]  DB_LAST    = 8'(DEBOUNCE_MS - 1);
    localparam logic [15:0] GREET_LAST = 16'(GREET_MS - 1);
    localparam logic [15:0] OVER_LAST  = 16'(OVER_MS - 1);
    localparam logic [15:0] INACT_LAST = 16'(INACT_MS - 1);

    // bit 0 = start, bit 1 = step, bit 2 = quit
    logic [2:0] w_btn_raw;
    logic [2:0] r_s1;
    logic [2:0] r_s2;
    logic [2:0] r_db;
    logic [2:0] r_db_q;
    logic [7:0] r_cnt [3];
    logic [2:0] w_press;

    assign w_btn_raw = {bus.btn_quit, bus.btn_step, bus.btn_start};

    always_ff @(posedge clk_1KHz or negedge rst_n) begin
        if (!rst_n) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_db   <= '0;
            r_db_q <= '0;
            for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
        end else begin
            r_s1   <= w_btn_raw;
            r_s2   <= r_s1;
            r_db_q <= r_db;
            for (int i = 0; i < 3; i++) begin
                // any disagreement must persist DEBOUNCE_MS consecutive cycles
                if (r_s2[i] != r_db[i]) begin
                    if (r_cnt[i] == DB_LAST) begin
                        r_db[i]  <= r_s2[i];
                        r_cnt[i] <= '0;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + 8'd1;
                    end
                end else begin
                    r_cnt[i] <= '0;
                end
            end
        end
    end

    assign w_press = r_db & ~r_db_q;

    logic        w_start;
    logic        w_step;
    logic        w_quit;
    state_t      r_state;
    logic [3:0]  r_state_q;
    logic        r_state_chg;
    logic [1:0]  r_cause;
    logic [15:0] r_timer;
    logic [15:0] w_timer_inc;

    assign w_start     = w_press[0];
    assign w_step      = w_press[1];
    assign w_quit      = w_press[2];
    assign w_timer_inc = (r_timer == 16'hFFFF) ? r_timer : r_timer + 16'd1;

    // Every branch that moves r_state also zeroes r_timer, overriding the default increment.
    always_ff @(posedge clk_1KHz or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_state_q   <= 4'd0;
            r_state_chg <= 1'b0;
            r_cause     <= CAUSE_NONE;
            r_timer     <= '0;
        end else begin
            r_state_q   <= r_state;
            r_state_chg <= (r_state != r_state_q);
            r_timer     <= w_timer_inc;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state <= ST_HOLA;
                        r_timer <= '0;
                    end
                end
                ST_HOLA: begin
                    if (w_quit) begin
                        r_state <= ST_IDLE;
                        r_timer <= '0;
                    end else if (w_start || r_timer == GREET_LAST) begin
                        r_state <= ST_PLAY1;
                        r_timer <= '0;
                    end
                end
                ST_PLAY1, ST_PLAY2, ST_PLAY3, ST_PLAY4: begin
                    if (w_quit) begin
                        r_state <= ST_OVER;
                        r_cause <= CAUSE_QUIT;
                        r_timer <= '0;
                    end else if (w_step) begin
                        r_timer <= '0;
                        if (r_state == ST_PLAY4) begin
                            r_state <= ST_OVER;
                            r_cause <= CAUSE_DONE;
                        end else begin
                            r_state <= state_t'(r_state + 4'd1);
                        end
                    end else if (r_timer == INACT_LAST) begin
                        r_state <= ST_OVER;
                        r_cause <= CAUSE_TMO;
                        r_timer <= '0;
                    end
                end
                ST_OVER: begin
                    if (w_start || r_timer == OVER_LAST) begin
                        r_state <= ST_IDLE;
                        r_cause <= CAUSE_NONE;
                        r_timer <= '0;
                    end
                end
                default: begin
                    // unreachable codes recover to IDLE
                    r_state <= ST_IDLE;
                    r_cause <= CAUSE_NONE;
                    r_timer <= '0;
                end
            endcase
        end
    end

    assign bus.state      = r_state;
    assign bus.over_cause = r_cause;
    assign bus.state_chg  = r_state_chg;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl: reset, start/greet, stepping to completion, quit priority,
// glitch rejection, inactivity timeout and restart, async reset with a held button.
// Outputs are sampled 1 ns after each rising edge; inputs change at the same point.
module tb_game_state_ctrl;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    game_state_ctrl_if u_if();

    game_state_ctrl #(
        .DEBOUNCE_MS(20),
        .GREET_MS   (5),
        .OVER_MS    (30),
        .INACT_MS   (50)
    ) dut (
        .clk_1KHz(clk),
        .rst_n   (rst_n),
        .bus     (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // one step press: state moves 23 edges after the button goes high; 48-cycle period
    task automatic step_press(input int exp_state);
        u_if.btn_step = 1'b1;
        tick(22);
        chk("step_pre", u_if.state, exp_state - 1);
        tick(1);
        chk("step_post", u_if.state, exp_state);
        tick(1);
        u_if.btn_step = 1'b0;
        tick(24);
    endtask

    // IDLE -> HOLA -> PLAY1 -> PLAY2, ends at the edge PLAY2 is entered with step released
    task automatic go_play2();
        u_if.btn_start = 1'b1;
        tick(23);
        chk("go_hola", u_if.state, 1);
        tick(5);
        chk("go_play1", u_if.state, 2);
        u_if.btn_start = 1'b0;
        u_if.btn_step  = 1'b1;
        tick(23);
        chk("go_play2", u_if.state, 3);
        u_if.btn_step = 1'b0;
    endtask

    task automatic go_play3();
        go_play2();
        tick(22);
        u_if.btn_step = 1'b1;
        tick(23);
        chk("go_play3", u_if.state, 4);
        u_if.btn_step = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n          = 1'b0;
        u_if.btn_start = 1'b0;
        u_if.btn_step  = 1'b0;
        u_if.btn_quit  = 1'b0;
        tick(3);
        chk("rst_state", u_if.state, 0);
        chk("rst_cause", u_if.over_cause, 0);
        chk("rst_chg", u_if.state_chg, 0);

        // start held from edge 1: HOLA at edge 23, pulse at 24, PLAY1 at 28
        rst_n          = 1'b1;
        u_if.btn_start = 1'b1;
        tick(22);
        chk("start_e22", u_if.state, 0);
        tick(1);
        chk("start_e23", u_if.state, 1);
        chk("chg_e23", u_if.state_chg, 0);
        tick(1);
        chk("chg_e24", u_if.state_chg, 1);
        tick(1);
        chk("chg_e25", u_if.state_chg, 0);
        tick(2);
        chk("hola_e27", u_if.state, 1);
        tick(1);
        chk("greet_e28", u_if.state, 2);
        chk("greet_chg_e28", u_if.state_chg, 0);
        tick(1);
        chk("greet_chg_e29", u_if.state_chg, 1);
        u_if.btn_start = 1'b0;

        // four steps to completion, then OVER times out after 30 cycles
        step_press(3);
        step_press(4);
        step_press(5);
        step_press(6);
        chk("done_state", u_if.state, 6);
        chk("done_cause", u_if.over_cause, 1);
        tick(4);
        chk("over_hold", u_if.state, 6);
        tick(1);
        chk("over_exit", u_if.state, 0);
        chk("over_exit_cause", u_if.over_cause, 0);
        tick(1);
        chk("over_exit_chg", u_if.state_chg, 1);

        // PLAY2: 10-cycle step glitch is ignored, inactivity timeout at cycle 50
        go_play2();
        tick(22);
        u_if.btn_step = 1'b1;
        tick(10);
        u_if.btn_step = 1'b0;
        tick(17);
        chk("glitch_c49", u_if.state, 3);
        tick(1);
        chk("tmo_state", u_if.state, 6);
        chk("tmo_cause", u_if.over_cause, 3);
        tick(30);
        chk("tmo_idle", u_if.state, 0);

        // step accepted at cycle 45 of PLAY2 restarts the window: OVER 50 cycles later
        go_play2();
        tick(22);
        u_if.btn_step = 1'b1;
        tick(22);
        chk("rst_win_pre", u_if.state, 3);
        tick(1);
        chk("rst_win_step", u_if.state, 4);
        tick(1);
        u_if.btn_step = 1'b0;
        tick(48);
        chk("rst_win_c49", u_if.state, 4);
        tick(1);
        chk("rst_win_tmo", u_if.state, 6);
        chk("rst_win_cause", u_if.over_cause, 3);
        tick(30);
        chk("rst_win_idle", u_if.state, 0);

        // PLAY3: quit and step debounce together, quit wins; then start leaves OVER early
        go_play3();
        tick(22);
        u_if.btn_quit = 1'b1;
        u_if.btn_step = 1'b1;
        tick(22);
        chk("qs_pre", u_if.state, 4);
        tick(1);
        chk("qs_state", u_if.state, 6);
        chk("qs_cause", u_if.over_cause, 2);
        u_if.btn_start = 1'b1;
        tick(22);
        chk("ovr_start_pre", u_if.state, 6);
        chk("ovr_start_cause", u_if.over_cause, 2);
        tick(1);
        chk("ovr_start_exit", u_if.state, 0);
        chk("ovr_start_cause0", u_if.over_cause, 0);
        u_if.btn_start = 1'b0;
        u_if.btn_quit  = 1'b0;
        u_if.btn_step  = 1'b0;
        tick(25);
        chk("idle_quiet", u_if.state, 0);

        // PLAY4 with start mid-debounce, async reset, held start gives one press after release
        go_play3();
        tick(22);
        u_if.btn_step = 1'b1;
        tick(23);
        chk("play4", u_if.state, 5);
        u_if.btn_step  = 1'b0;
        u_if.btn_start = 1'b1;
        tick(10);
        chk("play4_start_ign", u_if.state, 5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_state", u_if.state, 0);
        chk("arst_cause", u_if.over_cause, 0);
        chk("arst_chg", u_if.state_chg, 0);
        tick(3);
        rst_n = 1'b1;
        tick(22);
        chk("held_e22", u_if.state, 0);
        tick(1);
        chk("held_e23", u_if.state, 1);
        tick(5);
        chk("held_play1", u_if.state, 2);
        tick(30);
        chk("held_once", u_if.state, 2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
